tpu_out_drain: RTL and testbench
================================

Name: tpu_out_drain

Overview:
Result-drain engine for the next-generation TPU wrapper. After the systolic core finishes, it sequentially reads every row of NUM_BANKS output SRAM banks (one bank per batch) and streams them out on a valid/ready interface with bank/row tags. It sits between the per-batch output simple_sram instances and the host/testbench sink, replacing ad-hoc SRAM inspection. Bank count, row count and lane widths are generalised, and full backpressure is supported.

Parameters:
ARRAY_SIZE, 8, lanes per row
OUT_DATA_WIDTH, 16, signed width of one lane as stored in SRAM
NUM_BANKS, 3, output SRAM banks (= BATCH_SIZE)
ROWS, 2*ARRAY_SIZE-1, rows drained per bank (addresses 0..ROWS-1)
ROW_BITS, $clog2(ROWS), read-address width (MATRIX_BITS)
BANK_BITS, (NUM_BANKS>1)?$clog2(NUM_BANKS):1, bank tag width
NARROW_WIDTH, 8, lane width when saturation is compiled in

Ports:
clk  in  1  clock
srstn  in  1  asynchronous active-low reset
start  in  1  drain request pulse (wired to tpu_finish)
busy  out  1  high from accepted start until done
done  out  1  one-cycle pulse after the final beat handshake
sram_rd_en  out  NUM_BANKS  one-hot read enable; bit b selects bank b
sram_raddr  out  ROW_BITS  row address broadcast to all banks
sram_rdata  in  NUM_BANKS*ARRAY_SIZE*OUT_DATA_WIDTH  packed read data; bank b at slice b; valid 1 cycle after its read
out_valid  out  1  beat valid
out_ready  in  1  sink ready
out_data  out  ARRAY_SIZE*LANE_W  row data; LANE_W = OUT_DATA_WIDTH, or NARROW_WIDTH with the macro
out_bank  out  BANK_BITS  bank of the beat
out_row  out  ROW_BITS  row of the beat
out_last  out  1  high on the final beat (bank NUM_BANKS-1, row ROWS-1)

Behaviour:
- Reset (async, srstn=0): FSM=IDLE; busy, done, out_valid, out_last, sram_rd_en = 0; sram_raddr, out_bank, out_row, out_data = 0; counters and buffer cleared. Reset mid-drain aborts without emitting further beats.
- FSM IDLE -> ISSUE on start. start while busy is ignored.
- ISSUE: each cycle it may issue one read (rd_en one-hot for the current bank, raddr = current row). It issues only if (buffer occupancy + in-flight) < 2. Row increments on issue; at ROWS-1 it wraps to 0 and the bank increments. After issuing bank NUM_BANKS-1, row ROWS-1, go to FLUSH.
- Read latency is 1 cycle. The returned data plus its captured bank/row tag is written into a 2-entry FIFO (skid buffer). Lane data is selected from the bank slice recorded at issue, not the current bank.
- Output: out_* reflect the FIFO head; out_valid = FIFO non-empty. A beat transfers when out_valid && out_ready. out_data, out_bank and out_row are held stable while out_valid && !out_ready.
- Throughput: 1 beat/cycle with out_ready held high; first beat appears 2 cycles after start. Total beats = NUM_BANKS*ROWS, strictly in bank-major, row-minor order.
- FLUSH: wait until in-flight = 0 and FIFO empty, then DONE. DONE: done=1 for one cycle, busy=0, return to IDLE. A start in the DONE cycle is ignored.
- sram_rd_en = 0 whenever no read is issued. sram_raddr holds its last value.

Optional Feature:
TPU_DRAIN_SAT_EN: when defined, each lane is saturated from signed OUT_DATA_WIDTH to signed NARROW_WIDTH (clamp to [-2^(NARROW_WIDTH-1), 2^(NARROW_WIDTH-1)-1]) at FIFO write, and LANE_W = NARROW_WIDTH. When undefined, lanes pass through unchanged and LANE_W = OUT_DATA_WIDTH. Timing is identical in both builds.

Decomposition:
- Package tpu_drain_pkg: FSM state enum (IDLE, ISSUE, FLUSH, DONE), LANE_W derivation, saturation function.
- One sub-module: tpu_drain_skid, a 2-entry FIFO carrying {data, bank, row, last} with valid/ready. Issue counters and the FSM stay in the top level.

Test Plan:
- ARRAY_SIZE=2, NUM_BANKS=3, ROWS=3; bank b row r lanes = {b*16+r, -(b*16+r)}; out_ready=1; pulse start -> 9 beats on consecutive cycles; first beat at start+2; tags (0,0)..(2,2); out_last only on (2,2); done 1 cycle after the last beat; busy low afterwards.
- Same config, out_ready toggling 1,0,0,1 -> all 9 beats in order, no duplicates or drops; out_data stable during stalls; never more than 2 outstanding reads.
- out_ready=0 for 20 cycles after start -> exactly 2 reads issued, then sram_rd_en=0 until ready returns; drain then completes normally.
- start pulsed again mid-drain, and again in the DONE cycle -> ignored; exactly 9 beats and one done pulse.
- srstn asserted after 4 beats -> all outputs 0 immediately; a new start afterwards drains from (0,0) with 9 beats.
- TPU_DRAIN_SAT_EN, NARROW_WIDTH=8; lanes 300, -300, 127, -128 -> out lanes 127, -128, 127, -128.

Source files
------------

// File: rtl/tpu_drain_pkg.sv
// rtl/tpu_drain_pkg.sv - drain FSM states, lane width and saturation helpers (optional feature macro: TPU_DRAIN_SAT_EN)
package tpu_drain_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    FLUSH = 2'd2,
    DONE  = 2'd3
  } drain_state_t;

`ifdef TPU_DRAIN_SAT_EN
  localparam bit SAT_EN = 1'b1;
`else
  localparam bit SAT_EN = 1'b0;
`endif

  // Width of one lane as presented on the output port
  function automatic int lane_width(input int out_w, input int narrow_w);
    return SAT_EN ? narrow_w : out_w;
  endfunction

  // Clamp a sign-extended lane into the signed range of narrow_w bits
  function automatic logic signed [31:0] sat_lane(input logic signed [31:0] v, input int narrow_w);
    logic signed [31:0] hi;
    logic signed [31:0] lo;
    hi = (32'sd1 <<< (narrow_w - 1)) - 32'sd1;
    lo = -hi - 32'sd1;
    if (v > hi) return hi;
    else if (v < lo) return lo;
    else return v;
  endfunction

endpackage

// File: rtl/tpu_drain_skid.sv
// rtl/tpu_drain_skid.sv - 2-entry FIFO holding tagged drain beats between SRAM return and the sink
module tpu_drain_skid #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         srstn,
  input  logic         i_wvalid,
  input  logic [W-1:0] i_wdata,
  output logic         o_tvalid,
  input  logic         i_tready,
  output logic [W-1:0] o_tdata,
  output logic [1:0]   o_count
);

  logic [W-1:0] r_mem [2];
  logic         r_wptr;
  logic         r_rptr;
  logic [1:0]   r_count;
  logic         w_pop;

  assign o_tvalid = (r_count != 2'd0);
  assign o_tdata  = r_mem[r_rptr];
  assign o_count  = r_count;
  assign w_pop    = o_tvalid && i_tready;

  // Storage, pointers and occupancy; the producer never writes when two entries are held
  always_ff @(posedge clk or negedge srstn) begin
    if (!srstn) begin
      r_mem[0] <= '0;
      r_mem[1] <= '0;
      r_wptr   <= 1'b0;
      r_rptr   <= 1'b0;
      r_count  <= 2'd0;
    end else begin
      if (i_wvalid) begin
        r_mem[r_wptr] <= i_wdata;
        r_wptr        <= ~r_wptr;
      end
      if (w_pop) begin
        r_rptr <= ~r_rptr;
      end
      r_count <= r_count + {1'b0, i_wvalid} - {1'b0, w_pop};
    end
  end

endmodule

// File: rtl/tpu_out_drain.sv
// rtl/tpu_out_drain.sv - drains NUM_BANKS output SRAM banks row by row onto a tagged valid/ready stream (optional feature macro: TPU_DRAIN_SAT_EN)
module tpu_out_drain
  import tpu_drain_pkg::*;
#(
  parameter int ARRAY_SIZE     = 8,
  parameter int OUT_DATA_WIDTH = 16,
  parameter int NUM_BANKS      = 3,
  parameter int ROWS           = 2*ARRAY_SIZE-1,
  parameter int ROW_BITS       = $clog2(ROWS),
  parameter int BANK_BITS      = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 1,
  parameter int NARROW_WIDTH   = 8,
  localparam int LANE_W        = lane_width(OUT_DATA_WIDTH, NARROW_WIDTH)
) (
  input  logic                                         clk,
  input  logic                                         srstn,
  input  logic                                         start,
  output logic                                         busy,
  output logic                                         done,
  output logic [NUM_BANKS-1:0]                         sram_rd_en,
  output logic [ROW_BITS-1:0]                          sram_raddr,
  input  logic [NUM_BANKS*ARRAY_SIZE*OUT_DATA_WIDTH-1:0] sram_rdata,
  output logic                                         out_valid,
  input  logic                                         out_ready,
  output logic [ARRAY_SIZE*LANE_W-1:0]                 out_data,
  output logic [BANK_BITS-1:0]                         out_bank,
  output logic [ROW_BITS-1:0]                          out_row,
  output logic                                         out_last
);

  localparam int DW = ARRAY_SIZE * LANE_W;
  localparam int PW = DW + BANK_BITS + ROW_BITS + 1;

  drain_state_t         r_state;
  drain_state_t         w_state_nxt;
  logic [BANK_BITS-1:0] r_bank;
  logic [ROW_BITS-1:0]  r_row;
  logic [ROW_BITS-1:0]  r_raddr;
  logic                 r_inflight;
  logic [BANK_BITS-1:0] r_if_bank;
  logic [ROW_BITS-1:0]  r_if_row;
  logic                 r_if_last;
  logic                 w_issue;
  logic                 w_issue_last;
  logic                 w_pop;
  logic                 w_fifo_valid;
  logic [1:0]           w_fifo_cnt;
  logic [2:0]           w_pending;
  logic [DW-1:0]        w_lanes;
  logic [PW-1:0]        w_wdata;
  logic [PW-1:0]        w_head;

  // Reads still owed to the sink once this cycle's pop (if any) is taken out
  assign w_pop        = w_fifo_valid && out_ready;
  assign w_pending    = {1'b0, w_fifo_cnt} + {2'b0, r_inflight} - {2'b0, w_pop};
  assign w_issue_last = (r_bank == BANK_BITS'(NUM_BANKS - 1)) && (r_row == ROW_BITS'(ROWS - 1));

  assign sram_rd_en = w_issue ? (NUM_BANKS'(1) << r_bank) : '0;
  assign sram_raddr = w_issue ? r_row : r_raddr;

  // State register
  always_ff @(posedge clk or negedge srstn) begin
    if (!srstn) r_state <= IDLE;
    else        r_state <= w_state_nxt;
  end

  // Next state, read issue decision and status outputs
  always_comb begin
    w_state_nxt = r_state;
    w_issue     = 1'b0;
    busy        = 1'b0;
    done        = 1'b0;
    case (r_state)
      IDLE: begin
        if (start) w_state_nxt = ISSUE;
      end
      ISSUE: begin
        busy = 1'b1;
        if (w_pending < 3'd2) begin
          w_issue = 1'b1;
          if (w_issue_last) w_state_nxt = FLUSH;
        end
      end
      FLUSH: begin
        busy = 1'b1;
        if (w_pending == 3'd0) w_state_nxt = DONE;
      end
      DONE: begin
        done        = 1'b1;
        w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // Bank/row walk and the tag of the read returning next cycle; counters land back at (0,0) after the last issue
  always_ff @(posedge clk or negedge srstn) begin
    if (!srstn) begin
      r_bank     <= '0;
      r_row      <= '0;
      r_raddr    <= '0;
      r_inflight <= 1'b0;
      r_if_bank  <= '0;
      r_if_row   <= '0;
      r_if_last  <= 1'b0;
    end else begin
      r_inflight <= w_issue;
      if (w_issue) begin
        r_if_bank <= r_bank;
        r_if_row  <= r_row;
        r_if_last <= w_issue_last;
        r_raddr   <= r_row;
        if (r_row == ROW_BITS'(ROWS - 1)) begin
          r_row  <= '0;
          r_bank <= w_issue_last ? '0 : r_bank + 1'b1;
        end else begin
          r_row <= r_row + 1'b1;
        end
      end
    end
  end

  // Lanes come from the bank tagged at issue, not the bank currently being walked
  always_comb begin
    w_lanes = '0;
    for (int l = 0; l < ARRAY_SIZE; l++) begin
`ifdef TPU_DRAIN_SAT_EN
      w_lanes[l*LANE_W +: LANE_W] = LANE_W'(sat_lane(32'(signed'(
        sram_rdata[(int'(r_if_bank)*ARRAY_SIZE + l)*OUT_DATA_WIDTH +: OUT_DATA_WIDTH])), NARROW_WIDTH));
`else
      w_lanes[l*LANE_W +: LANE_W] =
        sram_rdata[(int'(r_if_bank)*ARRAY_SIZE + l)*OUT_DATA_WIDTH +: OUT_DATA_WIDTH];
`endif
    end
  end

  assign w_wdata = {w_lanes, r_if_bank, r_if_row, r_if_last};

  tpu_drain_skid #(.W(PW)) u_skid (
    .clk      (clk),
    .srstn    (srstn),
    .i_wvalid (r_inflight),
    .i_wdata  (w_wdata),
    .o_tvalid (w_fifo_valid),
    .i_tready (out_ready),
    .o_tdata  (w_head),
    .o_count  (w_fifo_cnt)
  );

  assign out_valid = w_fifo_valid;
  assign out_data  = w_head[PW-1 -: DW];
  assign out_bank  = w_head[ROW_BITS+1 +: BANK_BITS];
  assign out_row   = w_head[1 +: ROW_BITS];
  assign out_last  = w_fifo_valid && w_head[0];

endmodule

// File: tb/tb_tpu_out_drain.sv
// tb/tb_tpu_out_drain.sv - scoreboard bench for tpu_out_drain with a behavioural SRAM and drain-order model
module tb_tpu_out_drain;

  localparam int AS  = 2;
  localparam int ODW = 16;
  localparam int NB  = 3;
  localparam int RW  = 3;
  localparam int RB  = 2;
  localparam int BB  = 2;
  localparam int NW  = 8;
`ifdef TPU_DRAIN_SAT_EN
  localparam int LW = NW;
`else
  localparam int LW = ODW;
`endif
  localparam int DW = AS * LW;

  typedef struct {
    logic [DW-1:0] data;
    int            bank;
    int            row;
    bit            last;
  } beat_t;

  logic                  clk;
  logic                  srstn;
  logic                  start;
  logic                  busy;
  logic                  done;
  logic [NB-1:0]         sram_rd_en;
  logic [RB-1:0]         sram_raddr;
  logic [NB*AS*ODW-1:0]  sram_rdata;
  logic                  out_valid;
  logic                  out_ready;
  logic [DW-1:0]         out_data;
  logic [BB-1:0]         out_bank;
  logic [RB-1:0]         out_row;
  logic                  out_last;

  int    n_cmp = 0;
  int    n_err = 0;
  int    cyc = 0;
  int    mem [NB][RW][AS];
  beat_t exp_q[$];
  int    mode = 3;
  int    pidx = 0;
  logic [3:0] pat = 4'b1001;
  int    rd_cnt = 0;
  int    acc_cnt = 0;
  int    beats_total = 0;
  int    done_cnt = 0;
  int    last_cyc = -100;
  int    first_cyc = 0;
  int    start_cyc = 0;
  bit    first_pending = 0;
  bit    stall_prev = 0;
  logic [DW-1:0] hold_data;
  logic [BB-1:0] hold_bank;
  logic [RB-1:0] hold_row;

  tpu_out_drain #(
    .ARRAY_SIZE(AS), .OUT_DATA_WIDTH(ODW), .NUM_BANKS(NB), .ROWS(RW),
    .ROW_BITS(RB), .BANK_BITS(BB), .NARROW_WIDTH(NW)
  ) dut (
    .clk(clk), .srstn(srstn), .start(start), .busy(busy), .done(done),
    .sram_rd_en(sram_rd_en), .sram_raddr(sram_raddr), .sram_rdata(sram_rdata),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_bank(out_bank), .out_row(out_row), .out_last(out_last)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  // SRAM banks: one-cycle read latency; unread slices carry junk
  always @(posedge clk) begin
    for (int b = 0; b < NB; b++)
      for (int l = 0; l < AS; l++)
        sram_rdata[(b*AS+l)*ODW +: ODW] <= sram_rd_en[b] ? 16'(mem[b][sram_raddr][l]) : 16'($urandom);
  end

  // Sink readiness pattern
  initial begin
    out_ready = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      case (mode)
        0: out_ready = 1'b1;
        1: begin out_ready = pat[pidx]; pidx = (pidx + 1) % 4; end
        2: out_ready = 1'($urandom % 2);
        default: out_ready = 1'b0;
      endcase
    end
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [LW-1:0] lane_model(input int v);
    int c;
    c = v;
`ifdef TPU_DRAIN_SAT_EN
    if (c > (1 << (NW-1)) - 1) c = (1 << (NW-1)) - 1;
    if (c < -(1 << (NW-1)))    c = -(1 << (NW-1));
`endif
    return LW'(c);
  endfunction

  function automatic int rand_lane();
    logic signed [15:0] t;
    case ($urandom % 8)
      0: return 300;
      1: return -300;
      2: return 127;
      3: return -128;
      4: return 128;
      5: return -129;
      default: begin t = 16'($urandom); return int'(t); end
    endcase
  endfunction

  // Monitor: scoreboard pops, hold-under-stall, read order, outstanding bound, done timing
  always @(negedge clk) begin
    int k;
    beat_t e;
    if (!srstn) begin
      rd_cnt = 0;
      acc_cnt = 0;
      stall_prev = 0;
    end else begin
      if (stall_prev)
        check("stall_hold", {out_valid, out_data, out_bank, out_row}, {1'b1, hold_data, hold_bank, hold_row});
      stall_prev = out_valid && !out_ready;
      hold_data = out_data;
      hold_bank = out_bank;
      hold_row  = out_row;
      if (out_valid && out_ready) begin
        acc_cnt++;
        beats_total++;
        if (first_pending) begin
          check("first_beat_latency", cyc, start_cyc + 2);
          first_cyc = cyc;
          first_pending = 0;
        end
        if (exp_q.size() == 0) begin
          check("unexpected_beat", {out_bank, out_row}, 64'hDEAD);
        end else begin
          e = exp_q.pop_front();
          check("beat_data", out_data, e.data);
          check("beat_bank", out_bank, e.bank);
          check("beat_row", out_row, e.row);
          check("beat_last", out_last, e.last);
        end
        if (out_last) last_cyc = cyc;
      end
      if (|sram_rd_en) begin
        k = rd_cnt % (NB * RW);
        check("rd_sel", sram_rd_en, 64'd1 << (k / RW));
        check("rd_addr", sram_raddr, k % RW);
        rd_cnt++;
        check("outstanding_le2", (rd_cnt - acc_cnt) <= 2, 1);
      end
      if (done) begin
        done_cnt++;
        check("done_latency", cyc, last_cyc + 1);
        check("queue_empty_at_done", exp_q.size(), 0);
      end
    end
  end

  task automatic fill_pattern();
    for (int b = 0; b < NB; b++)
      for (int r = 0; r < RW; r++) begin
        mem[b][r][0] = b*16 + r;
        mem[b][r][1] = -(b*16 + r);
      end
  endtask

  task automatic fill_random();
    for (int b = 0; b < NB; b++)
      for (int r = 0; r < RW; r++)
        for (int l = 0; l < AS; l++)
          mem[b][r][l] = rand_lane();
  endtask

  task automatic do_start();
    beat_t e;
    logic [DW-1:0] d;
    for (int b = 0; b < NB; b++)
      for (int r = 0; r < RW; r++) begin
        d = '0;
        for (int l = 0; l < AS; l++) d[l*LW +: LW] = lane_model(mem[b][r][l]);
        e.data = d;
        e.bank = b;
        e.row  = r;
        e.last = (b == NB-1) && (r == RW-1);
        exp_q.push_back(e);
      end
    @(posedge clk);
    #1 start = 1'b1;
    @(posedge clk);
    #1 start_cyc = cyc;
    start = 1'b0;
  endtask

  task automatic wait_done(input int max, output bit got);
    got = 0;
    for (int n = 0; n < max && !got; n++) begin
      @(negedge clk);
      #1;
      if (done) got = 1;
    end
  endtask

  initial begin
    bit got;
    int d0;
    int b0;
    int r0;
    srstn = 1'b1;
    start = 1'b0;
    #2 srstn = 1'b0;
    fill_pattern();
    repeat (3) @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_valid", out_valid, 0);
    check("rst_last", out_last, 0);
    check("rst_rd_en", sram_rd_en, 0);
    check("rst_raddr", sram_raddr, 0);
    check("rst_bank", out_bank, 0);
    check("rst_row", out_row, 0);
    check("rst_data", out_data, 0);
    #1 srstn = 1'b1;

    // Full-rate drain of the reference pattern
    mode = 0;
    d0 = done_cnt;
    first_pending = 1;
    do_start();
    wait_done(100, got);
    check("t1_done_seen", got, 1);
    check("t1_beat_span", last_cyc - first_cyc, NB*RW - 1);
    check("t1_busy_in_done", busy, 0);
    check("t1_done_count", done_cnt - d0, 1);
    @(negedge clk);
    check("t1_busy_after", busy, 0);
    check("t1_valid_after", out_valid, 0);

    // Ready pattern 1,0,0,1
    fill_random();
    mode = 1;
    d0 = done_cnt;
    do_start();
    wait_done(300, got);
    check("t2_done_seen", got, 1);
    check("t2_done_count", done_cnt - d0, 1);

    // Ready held low: reads must stop at two
    fill_random();
    mode = 3;
    r0 = rd_cnt;
    do_start();
    repeat (20) @(negedge clk);
    #1;
    check("t3_reads_while_blocked", rd_cnt - r0, 2);
    check("t3_rd_en_idle", sram_rd_en, 0);
    check("t3_valid_held", out_valid, 1);
    mode = 0;
    wait_done(100, got);
    check("t3_done_seen", got, 1);

    // Starts while busy and in the DONE cycle are ignored
    fill_random();
    mode = 2;
    d0 = done_cnt;
    b0 = beats_total;
    do_start();
    repeat (5) @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    wait_done(300, got);
    check("t4_done_seen", got, 1);
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (15) @(negedge clk);
    check("t4_done_count", done_cnt - d0, 1);
    check("t4_beats", beats_total - b0, NB*RW);
    check("t4_busy_after", busy, 0);

    // Reset after four beats aborts; next drain restarts from (0,0)
    fill_random();
    mode = 0;
    b0 = beats_total;
    do_start();
    for (int n = 0; n < 50 && (beats_total - b0) < 4; n++) begin
      @(negedge clk);
      #1;
    end
    srstn = 1'b0;
    #1;
    check("t5_rst_out", {busy, done, out_valid, out_last, sram_rd_en, out_bank, out_row, out_data}, 0);
    exp_q.delete();
    repeat (2) @(negedge clk);
    #1 srstn = 1'b1;
    d0 = done_cnt;
    b0 = beats_total;
    do_start();
    wait_done(100, got);
    check("t5_done_seen", got, 1);
    check("t5_beats", beats_total - b0, NB*RW);
    check("t5_done_count", done_cnt - d0, 1);

    // Random data under random backpressure
    for (int it = 0; it < 3; it++) begin
      fill_random();
      mode = 2;
      do_start();
      wait_done(300, got);
      check("t6_done_seen", got, 1);
    end

    repeat (3) @(negedge clk);
    check("final_queue_empty", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
